bht_access_ctrl: RTL and testbench
==================================

Name: bht_access_ctrl

Overview:
- Initiator side of the bimodal BHT port. Drives index, domain, target, update enable and branch result into the BHT, and consumes its registered prediction and target outputs.
- Front end: issues lookups over a valid/ready channel from fetch.
- Back end: accepts in-order branch resolutions from execute and detects mispredicts.
- Sequences BHT updates under the BHT rule that an update lands on the previously presented index, and only when the index changes.

Parameters:
- IDX_W, `BHT_IDX_WIDTH, BHT index width.
- DEPTH, 4, in-flight prediction FIFO entries (power of 2, ≥2).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- lk_valid_i  in  1  lookup request
- lk_ready_o  out  1  lookup accepted when valid&ready
- lk_pc_i  in  32  branch PC
- lk_domain_i  in  domain_t  requesting domain
- pred_valid_o  out  1  prediction response valid
- pred_taken_o  out  1  predicted direction
- pred_targ_o  out  32  predicted target
- res_valid_i  in  1  resolution for oldest in-flight branch
- res_ready_o  out  1  resolution accepted
- res_taken_i  in  1  actual direction
- res_targ_i  in  32  actual taken target
- mispredict_o  out  1  one-cycle mispredict pulse
- redirect_targ_o  out  32  correct next PC, valid with mispredict_o
- bht_idx_o  out  IDX_W  BHT index
- bht_domain_o  out  domain_t  BHT domain
- bht_targ_o  out  32  target written on update
- bht_update_en_o  out  1  BHT update enable
- bht_br_result_o  out  1  BHT branch result
- bht_pred_i  in  1  BHT prediction, registered by the BHT
- bht_targ_i  in  32  BHT target, registered by the BHT

Behaviour:
- Reset, asynchronous: all outputs 0, bht_domain_o=INIT, state IDLE, FIFO empty, no lookup in flight.
- Index: idx = lk_pc_i[IDX_W+1:2].
- Lookup timing: accepted in cycle N, so bht_idx_o/bht_domain_o carry the request in N. In N+1, pred_valid_o=1 with pred_taken_o=bht_pred_i and pred_targ_o=bht_targ_i. The FIFO pushes {idx, domain, pc, pred, targ} in N+1. Latency is 1 cycle.
- Lookup readiness: lk_ready_o=1 only in IDLE with no resolve accepted that cycle and (count + in-flight lookup) < DEPTH, or in COMMIT as described below.
- res_ready_o=1 only in IDLE with the FIFO non-empty. A resolve pending in the same cycle as a lookup wins.
- States: IDLE, COMMIT, FLUSH.
- IDLE, resolve accepted:
  - Drive bht_idx_o/bht_domain_o from the FIFO head, bht_targ_o=res_targ_i, bht_update_en_o=0.
  - Register taken, targ and the head entry.
  - Next state COMMIT.
- IDLE, otherwise: drive the lookup request when accepted; hold the last value when idle. bht_update_en_o=0.
- COMMIT:
  - bht_update_en_o=1, bht_br_result_o=registered taken; pop the head.
  - mis = (taken != head.pred) | (taken & head.pred & targ != head.targ).
  - If mis is clear and a lookup is present, the FIFO has room, and its idx != held idx: accept it and drive its idx.
  - Otherwise lk_ready_o=0 and bht_idx_o = held idx ^ 1, so the index changes and the BHT commits the update.
  - If mis: mispredict_o=1; redirect_targ_o = taken ? targ : head.pc+4. Clear the FIFO and kill any lookup in flight (no pred_valid_o next cycle). Next state FLUSH.
  - If not mis: next state IDLE.
- FLUSH: one cycle; lk_ready_o=0, res_ready_o=0, bht_update_en_o=0. Next state IDLE.
- FIFO full: lookups stall; resolve still proceeds.
- FIFO empty: res_ready_o=0.
- FIFO pointers wrap modulo DEPTH.
- Reset asserted mid-update: the state machine returns to IDLE immediately; the update is lost.

Optional Feature:
- Macro BHT_GHIST_HASH_EN.
- Enabled: IDX_W-bit global history register, reset 0, shifted left with res_taken_i in the bit 0 position on every accepted resolve. Cleared to the history recorded at the resolved entry on a mispredict, so each FIFO entry also stores its ghist. Lookup idx = pc[IDX_W+1:2] ^ ghist.
- Disabled: no history register; idx = pc[IDX_W+1:2].

Test Plan:
- Lookup, pc=0x40, USER -> bht_idx_o=0x0 same cycle; next cycle pred_valid_o=1 with the BHT's outputs; FIFO count=1.
- Resolve taken, targ=0x100, predicted taken to 0x100 -> IDLE cycle drives idx 0x0 with targ 0x100; COMMIT has update_en=1 and br_result=1; no mispredict.
- Resolve not-taken on a predicted-taken pc=0x40 -> mispredict_o=1, redirect_targ_o=0x44; FIFO empties; lk_ready_o low for COMMIT and FLUSH.
- COMMIT with a lookup whose idx equals the held idx 0x3 -> bht_idx_o=0x2 and lk_ready_o=0; lookup accepted the following IDLE cycle.
- DEPTH=4: four lookups without resolve -> lk_ready_o=0 on the fifth; one resolve -> ready again after COMMIT.
- rst_ni pulsed low during COMMIT -> all outputs 0 and domain INIT immediately, with no clock edge required.

Source files
------------

// File: rtl/bht_access_ctrl.sv
// Bimodal BHT initiator: fetch lookups, in-order branch resolves and update sequencing.
// Optional global-history index hashing is enabled by defining BHT_GHIST_HASH_EN.
`ifndef BHT_IDX_WIDTH
`define BHT_IDX_WIDTH 4
`endif

package bht_access_ctrl_pkg;
  typedef enum logic [1:0] {INIT = 2'd0, USER = 2'd1, SUPER = 2'd2, MACH = 2'd3} domain_t;
endpackage

// state  | meaning
// IDLE   | serve lookups; a resolve presents the head index to the BHT
// COMMIT | update enabled, index moved off the head so the BHT commits it
// FLUSH  | one dead cycle after a mispredict
module bht_access_ctrl
  import bht_access_ctrl_pkg::*;
#(
  parameter int IDX_W = `BHT_IDX_WIDTH,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             lk_valid_i,
  output logic             lk_ready_o,
  input  logic [31:0]      lk_pc_i,
  input  domain_t          lk_domain_i,
  output logic             pred_valid_o,
  output logic             pred_taken_o,
  output logic [31:0]      pred_targ_o,
  input  logic             res_valid_i,
  output logic             res_ready_o,
  input  logic             res_taken_i,
  input  logic [31:0]      res_targ_i,
  output logic             mispredict_o,
  output logic [31:0]      redirect_targ_o,
  output logic [IDX_W-1:0] bht_idx_o,
  output domain_t          bht_domain_o,
  output logic [31:0]      bht_targ_o,
  output logic             bht_update_en_o,
  output logic             bht_br_result_o,
  input  logic             bht_pred_i,
  input  logic [31:0]      bht_targ_i
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  typedef enum logic [1:0] {IDLE, COMMIT, FLUSH} state_t;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    domain_t          dom;
    logic [31:0]      pc;
    logic             pred;
    logic [31:0]      targ;
`ifdef BHT_GHIST_HASH_EN
    logic [IDX_W-1:0] gh;
`endif
  } ent_t;

  state_t           r_state;
  ent_t             r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr, r_rd;
  logic [CNT_W-1:0] r_cnt;
  logic             r_lk_v;
  logic [IDX_W-1:0] r_lk_idx;
  domain_t          r_lk_dom;
  logic [31:0]      r_lk_pc;
  ent_t             r_head;
  logic             r_taken;
  logic [31:0]      r_targ;
  logic [IDX_W-1:0] r_idx_q;
  domain_t          r_dom_q;
  logic [31:0]      r_btarg_q;

  logic [IDX_W-1:0] w_lk_idx;
  ent_t             w_head, w_push_ent;
  logic [CNT_W-1:0] w_occ;
  logic             w_res_rdy, w_res_acc, w_lk_rdy, w_lk_acc;
  logic             w_mis, w_push, w_pop;
  logic [IDX_W-1:0] w_bidx;
  domain_t          w_bdom;
  logic [31:0]      w_btarg, w_redir;
  logic             w_upd, w_brres;

`ifdef BHT_GHIST_HASH_EN
  logic [IDX_W-1:0] r_ghist;
  logic [IDX_W-1:0] r_lk_gh;
  assign w_lk_idx = lk_pc_i[IDX_W+1:2] ^ r_ghist;
`else
  assign w_lk_idx = lk_pc_i[IDX_W+1:2];
`endif

  assign w_head    = r_mem[r_rd];
  assign w_occ     = r_cnt + CNT_W'(r_lk_v);
  assign w_res_rdy = rst_ni & (r_state == IDLE) & (r_cnt != '0);
  assign w_res_acc = w_res_rdy & res_valid_i;
  assign w_mis     = (r_state == COMMIT) &
                     ((r_taken != r_head.pred) | (r_taken & r_head.pred & (r_targ != r_head.targ)));
  assign w_lk_acc  = w_lk_rdy & lk_valid_i;
  assign w_push    = r_lk_v & ~w_mis;
  assign w_pop     = (r_state == COMMIT);

  always_comb begin
    w_lk_rdy = 1'b0;
    w_bidx   = r_idx_q;
    w_bdom   = r_dom_q;
    w_btarg  = r_btarg_q;
    w_upd    = 1'b0;
    w_brres  = 1'b0;
    w_redir  = '0;
    case (r_state)
      IDLE: begin
        if (w_res_acc) begin
          w_bidx  = w_head.idx;
          w_bdom  = w_head.dom;
          w_btarg = res_targ_i;
        end else begin
          w_lk_rdy = rst_ni & (w_occ < DEPTH_C);
          if (w_lk_rdy & lk_valid_i) begin
            w_bidx = w_lk_idx;
            w_bdom = lk_domain_i;
          end
        end
      end
      COMMIT: begin
        w_upd   = 1'b1;
        w_brres = r_taken;
        // head pops this cycle, so occupancy may reach DEPTH
        w_lk_rdy = rst_ni & ~w_mis & (w_occ <= DEPTH_C) & (w_lk_idx != r_head.idx);
        if (w_lk_rdy & lk_valid_i) begin
          w_bidx = w_lk_idx;
          w_bdom = lk_domain_i;
        end else begin
          w_bidx = r_head.idx ^ IDX_W'(1);
          w_bdom = r_head.dom;
        end
        if (w_mis) w_redir = r_taken ? r_targ : r_head.pc + 32'd4;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_push_ent      = '0;
    w_push_ent.idx  = r_lk_idx;
    w_push_ent.dom  = r_lk_dom;
    w_push_ent.pc   = r_lk_pc;
    w_push_ent.pred = bht_pred_i;
    w_push_ent.targ = bht_targ_i;
`ifdef BHT_GHIST_HASH_EN
    w_push_ent.gh   = r_lk_gh;
`endif
  end

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr] <= w_push_ent;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= IDLE;
      r_wr      <= '0;
      r_rd      <= '0;
      r_cnt     <= '0;
      r_lk_v    <= 1'b0;
      r_lk_idx  <= '0;
      r_lk_dom  <= INIT;
      r_lk_pc   <= '0;
      r_head    <= '0;
      r_taken   <= 1'b0;
      r_targ    <= '0;
      r_idx_q   <= '0;
      r_dom_q   <= INIT;
      r_btarg_q <= '0;
    end else begin
      r_idx_q   <= w_bidx;
      r_dom_q   <= w_bdom;
      r_btarg_q <= w_btarg;
      r_lk_v    <= w_lk_acc;
      if (w_lk_acc) begin
        r_lk_idx <= w_lk_idx;
        r_lk_dom <= lk_domain_i;
        r_lk_pc  <= lk_pc_i;
      end
      case (r_state)
        IDLE: begin
          if (w_res_acc) begin
            r_state <= COMMIT;
            r_head  <= w_head;
            r_taken <= res_taken_i;
            r_targ  <= res_targ_i;
          end
        end
        COMMIT:  r_state <= w_mis ? FLUSH : IDLE;
        default: r_state <= IDLE;
      endcase
      if (w_mis) begin
        r_wr  <= '0;
        r_rd  <= '0;
        r_cnt <= '0;
      end else begin
        if (w_push) r_wr <= r_wr + PTR_W'(1);
        if (w_pop)  r_rd <= r_rd + PTR_W'(1);
        r_cnt <= r_cnt + CNT_W'(w_push) - CNT_W'(w_pop);
      end
    end
  end

`ifdef BHT_GHIST_HASH_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_ghist <= '0;
      r_lk_gh <= '0;
    end else begin
      if (w_lk_acc) r_lk_gh <= r_ghist;
      if (w_mis)          r_ghist <= r_head.gh;
      else if (w_res_acc) r_ghist <= IDX_W'({r_ghist, res_taken_i});
    end
  end
`endif

  assign lk_ready_o      = w_lk_rdy;
  assign res_ready_o     = w_res_rdy;
  assign pred_valid_o    = r_lk_v;
  assign pred_taken_o    = r_lk_v & bht_pred_i;
  assign pred_targ_o     = r_lk_v ? bht_targ_i : '0;
  assign mispredict_o    = w_mis;
  assign redirect_targ_o = w_redir;
  assign bht_idx_o       = w_bidx;
  assign bht_domain_o    = w_bdom;
  assign bht_targ_o      = w_btarg;
  assign bht_update_en_o = w_upd;
  assign bht_br_result_o = w_brres;

endmodule

// File: tb/tb_bht_access_ctrl.sv
// Bench for bht_access_ctrl: queue-level reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_bht_access_ctrl;
  import bht_access_ctrl_pkg::*;

  localparam int IDX_W = 4;
  localparam int DEPTH = 4;
  localparam int PH_IDLE = 0, PH_COMMIT = 1, PH_FLUSH = 2;

  logic clk_i, rst_ni;
  logic lk_valid_i, lk_ready_o;
  logic [31:0] lk_pc_i;
  domain_t lk_domain_i;
  logic pred_valid_o, pred_taken_o;
  logic [31:0] pred_targ_o;
  logic res_valid_i, res_ready_o, res_taken_i;
  logic [31:0] res_targ_i;
  logic mispredict_o;
  logic [31:0] redirect_targ_o;
  logic [IDX_W-1:0] bht_idx_o;
  domain_t bht_domain_o;
  logic [31:0] bht_targ_o;
  logic bht_update_en_o, bht_br_result_o;
  logic bht_pred_i;
  logic [31:0] bht_targ_i;

  bht_access_ctrl #(.IDX_W(IDX_W), .DEPTH(DEPTH)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .lk_valid_i(lk_valid_i), .lk_ready_o(lk_ready_o), .lk_pc_i(lk_pc_i), .lk_domain_i(lk_domain_i),
    .pred_valid_o(pred_valid_o), .pred_taken_o(pred_taken_o), .pred_targ_o(pred_targ_o),
    .res_valid_i(res_valid_i), .res_ready_o(res_ready_o), .res_taken_i(res_taken_i),
    .res_targ_i(res_targ_i), .mispredict_o(mispredict_o), .redirect_targ_o(redirect_targ_o),
    .bht_idx_o(bht_idx_o), .bht_domain_o(bht_domain_o), .bht_targ_o(bht_targ_o),
    .bht_update_en_o(bht_update_en_o), .bht_br_result_o(bht_br_result_o),
    .bht_pred_i(bht_pred_i), .bht_targ_i(bht_targ_i)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  int n_chk, n_fail;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    domain_t          dom;
    logic [31:0]      pc;
    logic             pred;
    logic [31:0]      targ;
  } ment_t;

  // in-flight predictions, oldest first; the entry being committed is already removed
  ment_t mq[$];
  int m_phase;
  bit m_inflight;
  logic [IDX_W-1:0] m_lk_idx, m_last_idx;
  domain_t m_lk_dom, m_last_dom;
  logic [31:0] m_lk_pc, m_last_targ, m_targ;
  logic m_taken;
  ment_t m_head;

  task automatic m_reset();
    mq.delete();
    m_phase = PH_IDLE;
    m_inflight = 0;
    m_last_idx = '0;
    m_last_dom = INIT;
    m_last_targ = '0;
  endtask

  task automatic idle_in();
    lk_valid_i = 1'b0;
    res_valid_i = 1'b0;
  endtask

  task automatic advance();
    @(posedge clk_i);
    #1;
  endtask

  task automatic sample();
    logic e_lkr, e_rsr, e_upd, e_brr, e_mis, e_pv, e_pt;
    logic [IDX_W-1:0] e_idx, lk_idx;
    domain_t e_dom;
    logic [31:0] e_bt, e_red, e_ptg;
    bit res_acc, lk_acc;
    ment_t ne;
    @(negedge clk_i);
    lk_idx = lk_pc_i[IDX_W+1:2];
    e_lkr = 0; e_rsr = 0; e_upd = 0; e_brr = 0; e_mis = 0; e_red = '0;
    e_idx = m_last_idx; e_dom = m_last_dom; e_bt = m_last_targ;
    e_pv = m_inflight;
    e_pt = m_inflight ? bht_pred_i : 1'b0;
    e_ptg = m_inflight ? bht_targ_i : 32'h0;
    res_acc = 0; lk_acc = 0;
    if (m_phase == PH_IDLE) begin
      e_rsr = (mq.size() != 0);
      res_acc = e_rsr && res_valid_i;
      if (res_acc) begin
        e_idx = mq[0].idx; e_dom = mq[0].dom; e_bt = res_targ_i;
      end else begin
        e_lkr = (mq.size() + int'(m_inflight)) < DEPTH;
        lk_acc = e_lkr && lk_valid_i;
        if (lk_acc) begin e_idx = lk_idx; e_dom = lk_domain_i; end
      end
    end else if (m_phase == PH_COMMIT) begin
      e_upd = 1; e_brr = m_taken;
      e_mis = (m_taken != m_head.pred) || (m_taken && m_head.pred && m_targ != m_head.targ);
      if (e_mis) e_red = m_taken ? m_targ : m_head.pc + 32'd4;
      e_lkr = !e_mis && ((mq.size() + int'(m_inflight)) < DEPTH) && (lk_idx != m_head.idx);
      lk_acc = e_lkr && lk_valid_i;
      if (lk_acc) begin
        e_idx = lk_idx; e_dom = lk_domain_i;
      end else begin
        e_idx = m_head.idx ^ 4'd1; e_dom = m_head.dom;
      end
    end
    chk("lk_ready", lk_ready_o, e_lkr);
    chk("res_ready", res_ready_o, e_rsr);
    chk("bht_idx", bht_idx_o, e_idx);
    chk("bht_domain", bht_domain_o, e_dom);
    chk("bht_targ", bht_targ_o, e_bt);
    chk("update_en", bht_update_en_o, e_upd);
    chk("br_result", bht_br_result_o, e_brr);
    chk("mispredict", mispredict_o, e_mis);
    chk("redirect", redirect_targ_o, e_red);
    chk("pred_valid", pred_valid_o, e_pv);
    chk("pred_taken", pred_taken_o, e_pt);
    chk("pred_targ", pred_targ_o, e_ptg);
    if (res_acc) begin
      m_head = mq.pop_front();
      m_taken = res_taken_i;
      m_targ = res_targ_i;
    end
    if (m_inflight && !e_mis) begin
      ne.idx = m_lk_idx; ne.dom = m_lk_dom; ne.pc = m_lk_pc;
      ne.pred = bht_pred_i; ne.targ = bht_targ_i;
      mq.push_back(ne);
    end
    if (e_mis) mq.delete();
    m_inflight = lk_acc;
    if (lk_acc) begin m_lk_idx = lk_idx; m_lk_dom = lk_domain_i; m_lk_pc = lk_pc_i; end
    m_last_idx = e_idx; m_last_dom = e_dom; m_last_targ = e_bt;
    if (res_acc) m_phase = PH_COMMIT;
    else if (m_phase == PH_COMMIT) m_phase = e_mis ? PH_FLUSH : PH_IDLE;
    else m_phase = PH_IDLE;
  endtask

  task automatic lookup(logic [31:0] pc, domain_t dom);
    lk_valid_i = 1'b1; lk_pc_i = pc; lk_domain_i = dom;
  endtask

  task automatic resolve(logic taken, logic [31:0] targ);
    res_valid_i = 1'b1; res_taken_i = taken; res_targ_i = targ;
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    rst_ni = 1'b0;
    idle_in();
    lk_valid_i = 1'b1; lk_pc_i = 32'h40; lk_domain_i = USER;
    res_taken_i = 0; res_targ_i = '0; bht_pred_i = 0; bht_targ_i = '0;
    m_reset();
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_lk_ready", lk_ready_o, 0);
    chk("rst_res_ready", res_ready_o, 0);
    chk("rst_idx", bht_idx_o, 0);
    chk("rst_domain", bht_domain_o, INIT);
    chk("rst_pred_valid", pred_valid_o, 0);
    chk("rst_update_en", bht_update_en_o, 0);
    idle_in();
    @(negedge clk_i);
    rst_ni = 1'b1;
    advance();

    // single lookup, one-cycle prediction latency
    lookup(32'h40, USER);
    sample();
    chk("d1_idx", bht_idx_o, 4'h0);
    chk("d1_dom", bht_domain_o, USER);
    chk("d1_ready", lk_ready_o, 1);
    advance();
    idle_in(); bht_pred_i = 1; bht_targ_i = 32'h100;
    sample();
    chk("d1_pv", pred_valid_o, 1);
    chk("d1_pt", pred_taken_o, 1);
    chk("d1_ptarg", pred_targ_o, 32'h100);
    advance();
    sample();
    chk("d1_count1", res_ready_o, 1);
    advance();

    // correct taken resolve
    resolve(1, 32'h100);
    sample();
    chk("d2_idx", bht_idx_o, 4'h0);
    chk("d2_targ", bht_targ_o, 32'h100);
    chk("d2_upd0", bht_update_en_o, 0);
    advance();
    idle_in();
    sample();
    chk("d2_upd1", bht_update_en_o, 1);
    chk("d2_brres", bht_br_result_o, 1);
    chk("d2_nomis", mispredict_o, 0);
    advance();
    sample();
    chk("d2_empty", res_ready_o, 0);
    advance();

    // not-taken resolve on a predicted-taken branch
    lookup(32'h40, USER); sample(); advance();
    idle_in(); bht_pred_i = 1; bht_targ_i = 32'h100; sample(); advance();
    resolve(0, 32'h200); sample(); advance();
    idle_in(); lookup(32'h8, SUPER);
    sample();
    chk("d3_mis", mispredict_o, 1);
    chk("d3_redir", redirect_targ_o, 32'h44);
    chk("d3_lkr_commit", lk_ready_o, 0);
    advance();
    sample();
    chk("d3_lkr_flush", lk_ready_o, 0);
    chk("d3_rsr_flush", res_ready_o, 0);
    chk("d3_killed", pred_valid_o, 0);
    advance();
    idle_in();
    sample();
    chk("d3_empty", res_ready_o, 0);
    advance();

    // commit blocks a lookup that would keep the same index
    lookup(32'hC, USER); sample(); advance();
    idle_in(); bht_pred_i = 0; bht_targ_i = 32'h300; sample(); advance();
    resolve(0, 32'h300); sample(); advance();
    idle_in(); lookup(32'hC, USER);
    sample();
    chk("d4_idx_flip", bht_idx_o, 4'h2);
    chk("d4_lkr0", lk_ready_o, 0);
    advance();
    sample();
    chk("d4_lkr1", lk_ready_o, 1);
    chk("d4_idx", bht_idx_o, 4'h3);
    advance();
    idle_in(); bht_pred_i = 0; sample(); advance();
    resolve(0, 32'h0); sample(); advance();
    idle_in(); sample(); advance();

    // fill to DEPTH, then one resolve frees a slot
    bht_pred_i = 0;
    for (int i = 0; i < 6; i++) begin
      lookup(32'h1000 + 32'(i * 4), USER);
      sample();
      chk("d5_fill_ready", lk_ready_o, (i < DEPTH) ? 1 : 0);
      advance();
    end
    idle_in(); resolve(0, 32'h0);
    sample();
    chk("d5_full_rsr", res_ready_o, 1);
    advance();
    idle_in(); sample(); advance();
    sample();
    chk("d5_ready_after", lk_ready_o, 1);
    advance();

    // asynchronous reset in the middle of a commit
    resolve(0, 32'h0); sample(); advance();
    idle_in();
    rst_ni = 1'b0;
    #1;
    chk("d6_upd", bht_update_en_o, 0);
    chk("d6_idx", bht_idx_o, 0);
    chk("d6_dom", bht_domain_o, INIT);
    chk("d6_targ", bht_targ_o, 0);
    chk("d6_rsr", res_ready_o, 0);
    chk("d6_mis", mispredict_o, 0);
    m_reset();
    @(negedge clk_i);
    rst_ni = 1'b1;
    advance();

    for (int c = 0; c < 3000; c++) begin
      lk_valid_i = ($urandom_range(0, 9) < 6);
      lk_pc_i = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
      lk_domain_i = domain_t'($urandom_range(0, 3));
      res_valid_i = ($urandom_range(0, 9) < 4);
      bht_pred_i = $urandom_range(0, 1);
      bht_targ_i = 32'($urandom_range(1, 4)) << 8;
      if (mq.size() != 0 && $urandom_range(0, 3) != 0) res_taken_i = mq[0].pred;
      else res_taken_i = $urandom_range(0, 1);
      if (mq.size() != 0 && $urandom_range(0, 3) != 0) res_targ_i = mq[0].targ;
      else res_targ_i = 32'($urandom_range(1, 4)) << 8;
      sample();
      advance();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
